// File: rtl/sa_tile_sched.sv
// sa_tile_sched -- sequencer for one N x N systolic-array tile.
//
// Accepts a tile command (reduction length K plus A/B operand base addresses),
// issues K paired reads to the A/B operand buffers, drives feed valid into the
// skew chains one cycle after each read (buffer read latency = 1), pulses the
// PE accumulator clear on the first feed beat, waits for the array to drain and
// then pulses done for one cycle.
//
// Optional feature: define SA_SCHED_PERF_EN to build the busy/stall
// performance counters; otherwise perf_busy/perf_stall are tied to zero.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cmd_vld/cmd_rdy          tile command handshake (rdy only when idle)
//   cmd_k, cmd_a_base/b_base reduction length and operand base addresses
//   stall                    pause read issue while feeding
//   rd_en, rd_a_addr/b_addr  operand buffer read strobe and addresses
//   feed_vld, acc_clr        skew-chain valid and first-beat accumulator clear
//   busy, done               not idle / one-cycle tile-complete pulse
//   perf_busy, perf_stall    saturating busy and stalled-feed cycle counters
module sa_tile_sched #(
    parameter int N      = 4,
    parameter int K_W    = 8,
    parameter int ADDR_W = 8,
    parameter int PE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [K_W-1:0]    cmd_k,
    input  logic [ADDR_W-1:0] cmd_a_base,
    input  logic [ADDR_W-1:0] cmd_b_base,
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_a_addr,
    output logic [ADDR_W-1:0] rd_b_addr,
    output logic              feed_vld,
    output logic              acc_clr,
    output logic              busy,
    output logic              done,
    output logic [31:0]       perf_busy,
    output logic [31:0]       perf_stall
);

    // done lands DRAIN_CYC cycles after the last read: DRAIN_CYC-1 cycles in
    // DRAIN followed by the DONE cycle, so the counter is loaded with
    // DRAIN_CYC-2 and DRAIN is skipped entirely when DRAIN_CYC is 1.
    localparam int DRAIN_CYC  = 2 * (N - 1) + PE_LAT + 1;
    localparam int DCNT_W     = $clog2(DRAIN_CYC + 1);
    localparam int DRAIN_LOAD = (DRAIN_CYC >= 2) ? (DRAIN_CYC - 2) : 0;
    localparam bit HAS_DRAIN  = (DRAIN_CYC >= 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [K_W-1:0]    beats_left;
    logic [DCNT_W-1:0] drain_cnt;
    logic              first_beat;
    logic              vld_p1;
    logic              accept;

    assign accept = cmd_vld & cmd_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        cmd_rdy   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_rdy = 1'b1;
                busy    = 1'b0;
                if (cmd_vld) begin
                    state_nxt = (cmd_k == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                rd_en = ~stall;
                if (!stall && beats_left == K_W'(1)) begin
                    state_nxt = HAS_DRAIN ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: read issue -- command latch, address post-increment, beat count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_left <= '0;
            rd_a_addr  <= '0;
            rd_b_addr  <= '0;
            drain_cnt  <= '0;
        end else begin
            if (accept) begin
                beats_left <= cmd_k;
                rd_a_addr  <= cmd_a_base;
                rd_b_addr  <= cmd_b_base;
            end else if (rd_en) begin
                beats_left <= beats_left - K_W'(1);
                rd_a_addr  <= rd_a_addr + ADDR_W'(1);
                rd_b_addr  <= rd_b_addr + ADDR_W'(1);
            end
            if (state == FEED && state_nxt == DRAIN) begin
                drain_cnt <= DCNT_W'(DRAIN_LOAD);
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DCNT_W'(1);
            end
        end
    end

    // Stage p1: buffer data valid -- feed valid and first-beat accumulator clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            first_beat <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (accept) begin
                first_beat <= (cmd_k != '0);
            end else if (vld_p1) begin
                first_beat <= 1'b0;
            end
        end
    end

    assign feed_vld = vld_p1;
    assign acc_clr  = vld_p1 & first_beat;

`ifdef SA_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (busy && perf_busy != 32'hFFFF_FFFF) begin
                perf_busy <= perf_busy + 32'd1;
            end
            if (state == FEED && stall && perf_stall != 32'hFFFF_FFFF) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`else
    assign perf_busy  = 32'd0;
    assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_sa_tile_sched.sv
// tb_sa_tile_sched -- directed bench for sa_tile_sched (N=4, PE_LAT=1, so
// done follows the last read by 8 cycles). Each tile run records per-cycle
// traces relative to the accept cycle (bit c = cycle T+c) and compares them
// with hand-computed masks.
module tb_sa_tile_sched;

    logic        clk;
    logic        rst_n;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [7:0]  cmd_k;
    logic [7:0]  cmd_a_base;
    logic [7:0]  cmd_b_base;
    logic        stall;
    logic        rd_en;
    logic [7:0]  rd_a_addr;
    logic [7:0]  rd_b_addr;
    logic        feed_vld;
    logic        acc_clr;
    logic        busy;
    logic        done;
    logic [31:0] perf_busy;
    logic [31:0] perf_stall;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] tr_rd, tr_fv, tr_clr, tr_done, tr_rdy;
    logic [7:0]  tr_a [32];
    logic [7:0]  tr_b [32];
    int          busy_cnt;

    sa_tile_sched #(.N(4), .K_W(8), .ADDR_W(8), .PE_LAT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_vld    (cmd_vld),
        .cmd_rdy    (cmd_rdy),
        .cmd_k      (cmd_k),
        .cmd_a_base (cmd_a_base),
        .cmd_b_base (cmd_b_base),
        .stall      (stall),
        .rd_en      (rd_en),
        .rd_a_addr  (rd_a_addr),
        .rd_b_addr  (rd_b_addr),
        .feed_vld   (feed_vld),
        .acc_clr    (acc_clr),
        .busy       (busy),
        .done       (done),
        .perf_busy  (perf_busy),
        .perf_stall (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle 0 is the accept cycle; inputs are applied 1ns after the rising
    // edge and outputs sampled on the falling edge.
    task automatic run_tile(input logic [7:0] k, input logic [7:0] a, input logic [7:0] b,
                            input logic [31:0] vld_mask, input logic [31:0] stall_mask,
                            input int ncyc);
        tr_rd = '0; tr_fv = '0; tr_clr = '0; tr_done = '0; tr_rdy = '0;
        busy_cnt = 0;
        cmd_k      = k;
        cmd_a_base = a;
        cmd_b_base = b;
        for (int c = 0; c < ncyc; c++) begin
            cmd_vld = vld_mask[c];
            stall   = stall_mask[c];
            @(negedge clk);
            tr_rd[c]   = rd_en;
            tr_fv[c]   = feed_vld;
            tr_clr[c]  = acc_clr;
            tr_done[c] = done;
            tr_rdy[c]  = cmd_rdy;
            tr_a[c]    = rd_a_addr;
            tr_b[c]    = rd_b_addr;
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
        end
        cmd_vld = 1'b0;
        stall   = 1'b0;
    endtask

    logic [31:0] pb0, ps0;
    logic        saw_done;

    initial begin
        rst_n = 1'b0; cmd_vld = 1'b0; cmd_k = '0; cmd_a_base = '0; cmd_b_base = '0; stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_ctrl", {cmd_rdy, rd_en, feed_vld, acc_clr, busy, done}, 6'b100000);
        check_val("reset_addr", {rd_a_addr, rd_b_addr}, 16'h0000);
        check_val("reset_perf", {perf_busy, perf_stall}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: k=3, no stall
        pb0 = perf_busy;
        run_tile(8'd3, 8'h10, 8'h20, 32'h1, 32'h0, 13);
        check_val("t1_rd_en",   tr_rd,   32'h0000_000E);
        check_val("t1_feed",    tr_fv,   32'h0000_001C);
        check_val("t1_acc_clr", tr_clr,  32'h0000_0004);
        check_val("t1_done",    tr_done, 32'h0000_0800);
        check_val("t1_rdy",     tr_rdy,  32'h0000_1001);
        check_val("t1_addr",    {tr_a[1], tr_b[1], tr_a[2], tr_b[2], tr_a[3], tr_b[3]}, 48'h1020_1121_1222);
        check_val("t1_busy",    busy_cnt, 64'd11);
`ifdef SA_SCHED_PERF_EN
        check_val("t1_perf_busy", perf_busy - pb0, 64'd11);
`else
        check_val("t1_perf_off", {perf_busy, perf_stall}, 64'd0);
`endif

        // 2: k=0
        run_tile(8'd0, 8'h33, 8'h44, 32'h1, 32'h0, 3);
        check_val("t2_rd_fv_clr", {tr_rd[2:0], tr_fv[2:0], tr_clr[2:0]}, 9'd0);
        check_val("t2_done",      tr_done[2:0], 3'b010);
        check_val("t2_rdy",       tr_rdy[2:0],  3'b101);

        // 3: k=4, stall at T+2..T+3
        ps0 = perf_stall;
        run_tile(8'd4, 8'h10, 8'h20, 32'h1, 32'h0000_000C, 16);
        check_val("t3_rd_en",   tr_rd,   32'h0000_0072);
        check_val("t3_feed",    tr_fv,   32'h0000_00E4);
        check_val("t3_acc_clr", tr_clr,  32'h0000_0004);
        check_val("t3_done",    tr_done, 32'h0000_4000);
        check_val("t3_addr_hold", {tr_a[2], tr_a[3], tr_a[4], tr_a[5], tr_a[6]}, 40'h11_11_11_12_13);
`ifdef SA_SCHED_PERF_EN
        check_val("t3_perf_stall", perf_stall - ps0, 64'd2);
`endif

        // 4: address wrap
        run_tile(8'd4, 8'hFE, 8'hFF, 32'h1, 32'h0, 14);
        check_val("t4_a_wrap", {tr_a[1], tr_a[2], tr_a[3], tr_a[4]}, 32'hFEFF_0001);
        check_val("t4_b_wrap", {tr_b[1], tr_b[2], tr_b[3], tr_b[4]}, 32'hFF00_0102);
        check_val("t4_done",   tr_done, 32'h0000_1000);

        // 5: reset mid-tile (k=5, rst_n low at T+2)
        cmd_vld = 1'b1; cmd_k = 8'd5; cmd_a_base = 8'h40; cmd_b_base = 8'h50;
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        @(posedge clk);
        #1;
        check_val("t5_active", {rd_en, busy}, 2'b11);
        rst_n = 1'b0;
        #1;
        check_val("t5_async_ctrl", {cmd_rdy, rd_en, feed_vld, acc_clr, busy, done}, 6'b100000);
        check_val("t5_async_addr", {rd_a_addr, rd_b_addr}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check_val("t5_no_done", saw_done, 1'b0);
        @(posedge clk);
        #1;
        run_tile(8'd1, 8'h00, 8'h00, 32'h1, 32'h0, 11);
        check_val("t5_k1_done", tr_done, 32'h0000_0200);
        check_val("t5_k1_rd",   tr_rd,   32'h0000_0002);
        check_val("t5_k1_rdy",  tr_rdy,  32'h0000_0401);

        // 6: back-to-back k=2 tiles with cmd_vld held high
        pb0 = perf_busy;
        run_tile(8'd2, 8'h00, 8'h80, 32'h0000_0FFF, 32'h0, 24);
        check_val("t6_rd_en",   tr_rd,   32'h0000_3006);
        check_val("t6_acc_clr", tr_clr,  32'h0000_2004);
        check_val("t6_done",    tr_done, 32'h0020_0400);
        check_val("t6_rdy",     tr_rdy,  32'h00C0_0801);
        check_val("t6_busy",    busy_cnt, 64'd20);
`ifdef SA_SCHED_PERF_EN
        check_val("t6_perf_busy", perf_busy - pb0, 64'd20);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
